// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling FSM, one-cycle accept/error pulses.
// Optional receive FIFO compiled in with `define UART_RX_FIFO_EN.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_in,
  input  logic       rd,
  output logic [7:0] rx_data,
  output logic       rx_interrupt,
  output logic       frame_err,
  output logic       fifo_empty,
  output logic       overrun
);

  localparam int              CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cyc_cnt, cyc_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    shift_reg, shift_n;
  logic [1:0]    sync_q;
  logic          rxs;
  logic          accept;
  logic          stop_low;

  // Synchroniser resets to the idle line level so reset cannot fake a start bit.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], uart_in};
  end

  assign rxs = sync_q[1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cyc_cnt      <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      rx_interrupt <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_n;
      cyc_cnt      <= cyc_n;
      bit_cnt      <= bit_n;
      shift_reg    <= shift_n;
      rx_interrupt <= accept;
      frame_err    <= stop_low;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n  = state;
    cyc_n    = cyc_cnt + CW'(1);
    bit_n    = bit_cnt;
    shift_n  = shift_reg;
    accept   = 1'b0;
    stop_low = 1'b0;
    unique case (state)
      IDLE: begin
        cyc_n = '0;
        if (!rxs) state_n = START;
      end
      START: begin
        if (cyc_cnt == HALF_END) begin
          cyc_n   = '0;
          bit_n   = '0;
          state_n = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cyc_cnt == BIT_END) begin
          cyc_n   = '0;
          shift_n = {rxs, shift_reg[7:1]};
          bit_n   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cyc_cnt == BIT_END) begin
          cyc_n = '0;
          if (rxs) begin
            accept  = 1'b1;
            state_n = IDLE;
          end else begin
            stop_low = 1'b1;
            state_n  = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // A held-low break must return high before a new start is armed.
        cyc_n = '0;
        if (rxs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, push_ok;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign pop     = rd && (count != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = accept && (!full || pop);

  // NOTE: the storage array has no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shift_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      overrun <= accept && !push_ok;
    end
  end

  assign rx_data    = mem[rd_ptr];
  assign fifo_empty = (count == '0);
`else
  localparam int unused_fifo_depth = FIFO_DEPTH;
  logic          unused_rd;

  assign unused_rd = rd;

  always_ff @(posedge clk) begin
    if (reset)       rx_data <= 8'h00;
    else if (accept) rx_data <= shift_reg;
  end

  assign fifo_empty = 1'b1;
  assign overrun    = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver feeding the CPU's int3 line (uart_rx_interrupt) and the MemoryUnit's UART read register.
- Synchronises the asynchronous uart_in pin, detects the start bit, samples each bit at mid-bit, and presents the received byte.
- Raises a one-cycle interrupt pulse per accepted byte.
- Lives inside the MemoryUnit I/O space, clocked by the 50 MHz system clk.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); minimum legal value 4.
- FIFO_DEPTH, 4, receive FIFO entries, power of two; used only when UART_RX_FIFO_EN is defined.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- uart_in  in  1  serial line, idle high, asynchronous to clk
- rd  in  1  FIFO pop strobe, one cycle (see Optional Feature)
- rx_data  out  8  last accepted byte, or FIFO head when the FIFO is compiled in
- rx_interrupt  out  1  one-cycle pulse per accepted byte; drives CPU int3
- frame_err  out  1  one-cycle pulse when the stop bit samples low
- fifo_empty  out  1  high when no unread byte is held in the FIFO
- overrun  out  1  one-cycle pulse when a byte is dropped because the FIFO is full

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - State IDLE, bit counter 0, cycle counter 0.
  - Both synchroniser flops = 1.
  - rx_data = 8'h00, rx_interrupt = 0, frame_err = 0, overrun = 0, fifo_empty = 1.
  - FIFO pointers 0.
  - Reset asserted mid-frame aborts the frame; no pulse is emitted for it.
- Synchroniser: 2 flops on uart_in; the FSM uses only the second flop (rxs). Input-to-FSM latency is 2 cycles.
- FSM states IDLE, START, DATA, STOP, WAIT_IDLE:
  - IDLE: when rxs = 0, go to START and clear the cycle counter.
  - START: when the cycle counter reaches CLKS_PER_BIT/2 - 1 (integer divide), sample rxs.
    - rxs = 0: go to DATA, clear the cycle counter and the bit counter.
    - rxs = 1: treat as a glitch and return to IDLE with no output.
  - DATA: when the cycle counter reaches CLKS_PER_BIT - 1, sample rxs into the shift register LSB-first (shift right, new bit into bit 7), clear the cycle counter, and increment the bit counter. After the 8th sample, go to STOP.
  - STOP: when the cycle counter reaches CLKS_PER_BIT - 1, sample rxs.
    - rxs = 1: accept the byte and go to IDLE.
    - rxs = 0: assert frame_err for the next cycle, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rxs = 1, then go to IDLE. This prevents a break condition from retriggering the receiver.
- Accept timing:
  - rx_data updates on the cycle after the stop sample.
  - rx_interrupt is high for exactly that same cycle.
  - The next start bit can be detected on the cycle after the stop sample, because IDLE is entered immediately.
- Counters:
  - Cycle counter is clog2(CLKS_PER_BIT) bits wide.
  - Bit counter is 3 bits and wraps after bit 7.
- Without the FIFO, rx_data is held until the next accepted byte. A new byte overwrites it silently.

Optional Feature:
- Macro: UART_RX_FIFO_EN.
- Defined:
  - Accepted bytes are pushed into a FIFO_DEPTH-entry FIFO.
  - rx_data shows the FIFO head combinationally from storage; its value is undefined while fifo_empty = 1.
  - fifo_empty reflects occupancy == 0.
  - rd = 1 pops one entry, effective the next cycle. rd while empty is ignored.
  - Push while full drops the new byte and pulses overrun; rx_interrupt still pulses.
  - Simultaneous push and rd while full: the pop happens first, the push succeeds, and there is no overrun.
  - Simultaneous push and rd while empty: the push happens and the pop is ignored.
- Not defined:
  - rd is ignored, fifo_empty is constant 1, overrun is constant 0.
  - rx_data behaves as the single holding register.

Test Plan (CLKS_PER_BIT = 16):
- Reset, then line idle high for 200 cycles -> all outputs at reset values, no pulses.
- Send 0xA5 with a valid stop bit -> rx_interrupt high for 1 cycle, rx_data = 8'hA5; the pulse comes 2 + 8 + 8×16 + 16 cycles (±1) after the falling edge on uart_in.
- Drive a 5-cycle low glitch on an idle line -> no rx_interrupt, no frame_err, FSM back in IDLE.
- Send 0x3C with stop bit low, then hold the line low for 64 cycles -> exactly one frame_err pulse, rx_data unchanged, no rx_interrupt; then a valid 0x81 -> rx_data = 8'h81.
- Assert reset during bit 4 of a frame, release it, then send 0x55 -> no pulse for the aborted frame; 0x55 is received correctly.
- With UART_RX_FIFO_EN and FIFO_DEPTH = 4, send 0x01..0x05 without rd -> four interrupts with no overrun, then a fifth interrupt plus an overrun pulse. Then pop 4 times -> rx_data reads 0x01, 0x02, 0x03, 0x04, and fifo_empty = 1 after the 4th pop.
